// File: rtl/wshb_rect_fill.sv
// Wishbone classic-cycle write master that fills a clipped rectangle of the
// framebuffer in raster order, one 32-bit word per pixel at 4*(HDISP*y + x).
`timescale 1ns/1ps
module wshb_rect_fill #(
    parameter int HDISP = 800,
    parameter int VDISP = 480,
    parameter int GRID  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       mode,
    input  logic [$clog2(HDISP)-1:0]   x0,
    input  logic [$clog2(VDISP)-1:0]   y0,
    input  logic [$clog2(HDISP):0]     w,
    input  logic [$clog2(VDISP):0]     h,
    input  logic [23:0]                color,
    output logic                       busy,
    output logic                       done,
    output logic                       wshb_cyc,
    output logic                       wshb_stb,
    output logic                       wshb_we,
    output logic [31:0]                wshb_adr,
    output logic [31:0]                wshb_dat_ms,
    output logic [3:0]                 wshb_sel,
    output logic [2:0]                 wshb_cti,
    output logic [1:0]                 wshb_bte,
    input  logic                       wshb_ack
);

    localparam int XW  = $clog2(HDISP);
    localparam int YW  = $clog2(VDISP);
    localparam int XEW = XW + 2;
    localparam int YEW = YW + 2;
    localparam int GB  = $clog2(GRID);

    localparam logic [XEW-1:0] HDISP_X = XEW'(HDISP);
    localparam logic [YEW-1:0] VDISP_Y = YEW'(VDISP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            mode_q, mode_d;
    logic [23:0]     color_q, color_d;
    logic [XW-1:0]   x0_q, x0_d;
    logic [XEW-1:0]  x_end_q, x_end_d;
    logic [YEW-1:0]  y_end_q, y_end_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;

    logic [XEW-1:0]  x_sum;
    logic [YEW-1:0]  y_sum;
    logic [XEW-1:0]  x_end_c;
    logic [YEW-1:0]  y_end_c;
    logic            empty_c;
    logic            x_last;
    logic            y_last;
    logic            on_grid;
    logic [23:0]     pixel;
    logic [31:0]     pix_idx;

    // Widened sums cannot overflow, so the min() clip against the screen is exact.
    always_comb begin
        x_sum   = {2'b00, x0} + {1'b0, w};
        y_sum   = {2'b00, y0} + {1'b0, h};
        x_end_c = (x_sum > HDISP_X) ? HDISP_X : x_sum;
        y_end_c = (y_sum > VDISP_Y) ? VDISP_Y : y_sum;
        empty_c = (w == '0) || (h == '0) ||
                  ({2'b00, x0} >= HDISP_X) || ({2'b00, y0} >= VDISP_Y);
    end

    always_comb begin
        x_last = (({2'b00, x_q} + XEW'(1)) == x_end_q);
        y_last = (({2'b00, y_q} + YEW'(1)) == y_end_q);
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        color_d = color_q;
        x0_d    = x0_q;
        x_end_d = x_end_q;
        y_end_d = y_end_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    color_d = color;
                    x0_d    = x0;
                    x_end_d = x_end_c;
                    y_end_d = y_end_c;
                    x_d     = x0;
                    y_d     = y0;
                    state_d = empty_c ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                if (wshb_ack) begin
                    if (x_last && y_last) begin
                        state_d = S_DONE;
                    end else if (x_last) begin
                        x_d = x0_q;
                        y_d = y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            color_q <= '0;
            x0_q    <= '0;
            x_end_q <= '0;
            y_end_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            color_q <= color_d;
            x0_q    <= x0_d;
            x_end_q <= x_end_d;
            y_end_q <= y_end_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // Grid lines use absolute screen coordinates; GRID is a power of two.
    always_comb begin
        on_grid = (x_q[GB-1:0] == '0) || (y_q[GB-1:0] == '0);
        pixel   = (mode_q && on_grid) ? 24'hFF_FFFF : color_q;
        pix_idx = 32'(HDISP) * 32'(y_q) + 32'(x_q);
    end

    // Address and data follow the registered position, so they stay put until ack.
    assign wshb_adr    = {pix_idx[29:0], 2'b00};
    assign wshb_dat_ms = {8'h00, pixel};
    assign wshb_cyc    = (state_q == S_WRITE);
    assign wshb_stb    = (state_q == S_WRITE);
    assign wshb_we     = 1'b1;
    assign wshb_sel    = 4'b1111;
    assign wshb_cti    = 3'b000;
    assign wshb_bte    = 2'b00;
    assign busy        = (state_q == S_WRITE);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_wshb_rect_fill.sv
// Directed bench for wshb_rect_fill: a Wishbone slave with configurable wait
// states feeds a scoreboard of hand-computed addresses and pixel words.
`timescale 1ns/1ps
module tb_wshb_rect_fill;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [9:0]  x0;
    logic [8:0]  y0;
    logic [10:0] w;
    logic [9:0]  h;
    logic [23:0] color;
    logic        busy;
    logic        done;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_adr_q[$];
    logic [31:0] exp_dat_q[$];

    int          wait_n   = 0;
    int          wcnt     = 0;
    int          wr_cnt   = 0;
    int          done_cnt = 0;
    int          stb_cnt  = 0;
    bit          track    = 1'b1;
    logic [31:0] held_adr = '0;
    logic [31:0] held_dat = '0;

    wshb_rect_fill #(.HDISP(800), .VDISP(480), .GRID(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .x0          (x0),
        .y0          (y0),
        .w           (w),
        .h           (h),
        .color       (color),
        .busy        (busy),
        .done        (done),
        .wshb_cyc    (cyc),
        .wshb_stb    (stb),
        .wshb_we     (we),
        .wshb_adr    (adr),
        .wshb_dat_ms (dat),
        .wshb_sel    (sel),
        .wshb_cti    (cti),
        .wshb_bte    (bte),
        .wshb_ack    (ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
        exp_adr_q.push_back(a);
        exp_dat_q.push_back(d);
    endtask

    // Slave: decides ack at each falling edge; a transfer completes on the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            ack  = 1'b0;
            wcnt = 0;
        end else begin
            if (done) done_cnt++;
            if (stb) begin
                stb_cnt++;
                if (wcnt > 0 && track) begin
                    check("hold_adr", adr, held_adr);
                    check("hold_dat", dat, held_dat);
                end
                if (wcnt == 0) begin
                    held_adr = adr;
                    held_dat = dat;
                end
                if (wcnt >= wait_n) begin
                    ack  = 1'b1;
                    wcnt = 0;
                    wr_cnt++;
                    if (track) begin
                        if (exp_adr_q.size() == 0) begin
                            check("extra_write", adr, 32'hFFFF_FFFF);
                        end else begin
                            check("adr", adr, exp_adr_q.pop_front());
                            check("dat", dat, exp_dat_q.pop_front());
                        end
                    end
                end else begin
                    ack = 1'b0;
                    wcnt++;
                end
            end else begin
                if (wcnt > 0 && track) check("stb_hold", 32'(stb), 32'd1);
                ack  = 1'b0;
                wcnt = 0;
            end
        end
    end

    task automatic run_cmd(input logic m, input logic [9:0] cx0, input logic [8:0] cy0,
                           input logic [10:0] cw, input logic [9:0] ch, input logic [23:0] col,
                           input int waits, input int exp_wr, input bit poke);
        bit got;
        wait_n   = waits;
        wr_cnt   = 0;
        done_cnt = 0;
        stb_cnt  = 0;
        @(negedge clk);
        mode  = m;
        x0    = cx0;
        y0    = cy0;
        w     = cw;
        h     = ch;
        color = col;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scramble inputs after accept; the command must already be latched.
        mode  = ~m;
        x0    = ~cx0;
        y0    = 9'd0;
        w     = 11'd50;
        h     = 10'd5;
        color = ~col;
        if (exp_wr > 0) check("busy_on", 32'(busy), 32'd1);
        got = done;
        for (int i = 0; i < 4000 && !got; i++) begin
            start = (poke && i == 2);
            @(negedge clk);
            if (done) got = 1'b1;
        end
        start = 1'b0;
        if (!got) check("timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clk);
        check("done_cnt", 32'(done_cnt), 32'd1);
        check("wr_cnt", 32'(wr_cnt), 32'(exp_wr));
        check("stb_after", 32'(stb), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        check("exp_left", 32'(exp_adr_q.size()), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        x0    = '0;
        y0    = '0;
        w     = '0;
        h     = '0;
        color = '0;
        repeat (2) @(negedge clk);
        check("rst_cyc", 32'(cyc), 32'd0);
        check("rst_stb", 32'(stb), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_adr", adr, 32'd0);
        check("rst_dat", dat, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("we", 32'(we), 32'd1);
        check("sel", 32'(sel), 32'hF);
        check("cti", 32'(cti), 32'd0);
        check("bte", 32'(bte), 32'd0);

        // Asynchronous reset in the middle of a long fill.
        track  = 1'b0;
        wait_n = 0;
        mode   = 1'b0;
        x0     = 10'd0;
        y0     = 9'd0;
        w      = 11'd100;
        h      = 10'd1;
        color  = 24'h55AA55;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_cyc", 32'(cyc), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_cyc", 32'(cyc), 32'd0);
        check("arst_stb", 32'(stb), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_adr_q.delete();
        exp_dat_q.delete();
        track = 1'b1;

        // Solid 2x2, zero-wait slave.
        push_exp(32'd0,    32'h0012_3456);
        push_exp(32'd4,    32'h0012_3456);
        push_exp(32'd3200, 32'h0012_3456);
        push_exp(32'd3204, 32'h0012_3456);
        run_cmd(1'b0, 10'd0, 9'd0, 11'd2, 10'd2, 24'h123456, 0, 4, 1'b0);

        // Same fill, three wait states per write.
        push_exp(32'd0,    32'h0012_3456);
        push_exp(32'd4,    32'h0012_3456);
        push_exp(32'd3200, 32'h0012_3456);
        push_exp(32'd3204, 32'h0012_3456);
        run_cmd(1'b0, 10'd0, 9'd0, 11'd2, 10'd2, 24'h123456, 3, 4, 1'b0);

        // Bottom-right clip: only (798,479) and (799,479) remain.
        push_exp(32'd1535992, 32'h00AB_CDEF);
        push_exp(32'd1535996, 32'h00AB_CDEF);
        run_cmd(1'b0, 10'd798, 9'd479, 11'd5, 10'd3, 24'hABCDEF, 1, 2, 1'b0);

        // Empty regions: zero width, and a start column off screen.
        run_cmd(1'b0, 10'd5, 9'd5, 11'd0, 10'd4, 24'h111111, 0, 0, 1'b0);
        check("empty_w_stb", 32'(stb_cnt), 32'd0);
        run_cmd(1'b0, 10'd900, 9'd5, 11'd4, 10'd4, 24'h222222, 0, 0, 1'b0);
        check("empty_x_stb", 32'(stb_cnt), 32'd0);

        // Start pulsed mid-fill must be ignored.
        for (int i = 0; i < 8; i++) push_exp(32'd16040 + 32'(4 * i), 32'h0000_FF00);
        run_cmd(1'b0, 10'd10, 9'd5, 11'd8, 10'd1, 24'h00FF00, 0, 8, 1'b1);

        // Grid pattern straddling the x=16 grid line.
        push_exp(32'd60,   32'h00FF_FFFF);
        push_exp(32'd64,   32'h00FF_FFFF);
        push_exp(32'd68,   32'h00FF_FFFF);
        push_exp(32'd3260, 32'h0000_0000);
        push_exp(32'd3264, 32'h00FF_FFFF);
        push_exp(32'd3268, 32'h0000_0000);
        run_cmd(1'b1, 10'd15, 9'd0, 11'd3, 10'd2, 24'h000000, 1, 6, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
